// File: rtl/pe_array_pipe.sv
// SIMD PE array: PE_COUNT lanes of the pe unit behind a valid/ready pipeline,
// with per-lane pass-through masking and an optional horizontal sum reduction.

package pe_array_pipe_pkg;
    localparam int unsigned OP_SEL_WIDTH = 3;

    typedef enum logic [OP_SEL_WIDTH-1:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_MIN = 3'd5,
        OP_MAX = 3'd6
    } pe_op_e;
endpackage

module pe
    import pe_array_pipe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]   i_a,
    input  logic [DATA_WIDTH-1:0]   i_b,
    input  logic [OP_SEL_WIDTH-1:0] i_op,
    output logic [DATA_WIDTH-1:0]   o_y
);
    always_comb begin
        o_y = '0;
        case (i_op)
            OP_ADD:  o_y = i_a + i_b;
            OP_SUB:  o_y = i_a - i_b;
            OP_AND:  o_y = i_a & i_b;
            OP_OR:   o_y = i_a | i_b;
            OP_XOR:  o_y = i_a ^ i_b;
            OP_MIN:  o_y = ($signed(i_a) < $signed(i_b)) ? i_a : i_b;
            OP_MAX:  o_y = ($signed(i_a) > $signed(i_b)) ? i_a : i_b;
            default: o_y = '0;
        endcase
    end
endmodule

module pe_array_pipe
    import pe_array_pipe_pkg::*;
#(
    parameter int unsigned PE_COUNT    = 4,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned PIPE_STAGES = 2,
    parameter int unsigned RED_WIDTH   = DATA_WIDTH + $clog2(PE_COUNT) + 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [PE_COUNT*DATA_WIDTH-1:0] a,
    input  logic [PE_COUNT*DATA_WIDTH-1:0] b,
    input  logic [OP_SEL_WIDTH-1:0]        pe_op,
    input  logic [PE_COUNT-1:0]            lane_en,
    input  logic                           red_en,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [PE_COUNT*DATA_WIDTH-1:0] pe_out,
    output logic [RED_WIDTH-1:0]           red_out,
    output logic                           red_valid,
    output logic                           busy
);
    localparam int unsigned VW   = PE_COUNT * DATA_WIDTH;
    localparam int unsigned LAST = PIPE_STAGES - 1;

    logic [VW-1:0]       w_c;
    logic                w_adv;
    logic                w_busy;
    logic signed [RED_WIDTH-1:0]  w_sum;
    logic signed [DATA_WIDTH-1:0] w_lane;

    logic                r_vld [PIPE_STAGES];
    logic [VW-1:0]       r_res [PIPE_STAGES];
    logic [PE_COUNT-1:0] r_en  [PIPE_STAGES];
    logic                r_red [PIPE_STAGES];

    for (genvar g = 0; g < PE_COUNT; g++) begin : g_lane
        logic [DATA_WIDTH-1:0] w_pe;

        pe #(.DATA_WIDTH(DATA_WIDTH)) u_pe (
            .i_a  (a[g*DATA_WIDTH +: DATA_WIDTH]),
            .i_b  (b[g*DATA_WIDTH +: DATA_WIDTH]),
            .i_op (pe_op),
            .o_y  (w_pe)
        );

        // Masked lanes forward operand A untouched
        assign w_c[g*DATA_WIDTH +: DATA_WIDTH] = lane_en[g] ? w_pe : a[g*DATA_WIDTH +: DATA_WIDTH];
    end

    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    // Data registers only load behind a valid bit; bubbles move valid=0 only
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned s = 0; s < PIPE_STAGES; s++) begin
                r_vld[s] <= 1'b0;
                r_res[s] <= '0;
                r_en[s]  <= '0;
                r_red[s] <= 1'b0;
            end
        end else if (w_adv) begin
            r_vld[0] <= in_valid;
            if (in_valid) begin
                r_res[0] <= w_c;
                r_en[0]  <= lane_en;
                r_red[0] <= red_en;
            end
            for (int unsigned s = 1; s < PIPE_STAGES; s++) begin
                r_vld[s] <= r_vld[s-1];
                if (r_vld[s-1]) begin
                    r_res[s] <= r_res[s-1];
                    r_en[s]  <= r_en[s-1];
                    r_red[s] <= r_red[s-1];
                end
            end
        end
    end

    always_comb begin
        w_sum  = '0;
        w_lane = '0;
        for (int unsigned l = 0; l < PE_COUNT; l++) begin
            w_lane = r_res[LAST][l*DATA_WIDTH +: DATA_WIDTH];
            if (r_en[LAST][l]) begin
                w_sum = w_sum + RED_WIDTH'(w_lane);
            end
        end
    end

    always_comb begin
        w_busy = 1'b0;
        for (int unsigned s = 0; s < PIPE_STAGES; s++) begin
            w_busy = w_busy | r_vld[s];
        end
    end

    assign out_valid = r_vld[LAST];
    assign pe_out    = r_res[LAST];
    assign red_out   = w_sum;
    assign red_valid = r_vld[LAST] && r_red[LAST];
    assign busy      = w_busy;
endmodule

// File: tb/tb_pe_array_pipe.sv
// Scoreboard bench for pe_array_pipe: directed bundles push hand-computed
// results into a queue; a negedge monitor pops and compares on each handshake.

module tb_pe_array_pipe;
    import pe_array_pipe_pkg::*;

    localparam int unsigned PE  = 4;
    localparam int unsigned DW  = 32;
    localparam int unsigned PS  = 2;
    localparam int unsigned RW  = DW + $clog2(PE) + 1;

    typedef struct {
        logic [PE*DW-1:0] pe;
        logic             rv;
        logic [RW-1:0]    ro;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [PE*DW-1:0]    a = '0;
    logic [PE*DW-1:0]    b = '0;
    logic [2:0]          pe_op = '0;
    logic [PE-1:0]       lane_en = '0;
    logic                red_en = 1'b0;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic [PE*DW-1:0]    pe_out;
    logic [RW-1:0]       red_out;
    logic                red_valid;
    logic                busy;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   stall_from = -100;

    pe_array_pipe #(
        .PE_COUNT    (PE),
        .DATA_WIDTH  (DW),
        .PIPE_STAGES (PS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .pe_op     (pe_op),
        .lane_en   (lane_en),
        .red_en    (red_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pe_out    (pe_out),
        .red_out   (red_out),
        .red_valid (red_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        out_ready = !(cyc >= stall_from && cyc < stall_from + 3);
    end

    function automatic logic [PE*DW-1:0] pack(input logic [31:0] l0, input logic [31:0] l1,
                                              input logic [31:0] l2, input logic [31:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic chk(input string name, input logic [PE*DW-1:0] act, input logic [PE*DW-1:0] req);
        checks = checks + 1;
        if (act !== req) begin
            failures = failures + 1;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (q.size() == 0) begin
                checks = checks + 1;
                failures = failures + 1;
                $display("FAIL unexpected_output actual=%h required=none", pe_out);
            end else begin
                chk("pe_out", pe_out, q[0].pe);
                chk("red_valid", {127'b0, red_valid}, {127'b0, q[0].rv});
                if (q[0].rv) chk("red_out", {{(PE*DW-RW){1'b0}}, red_out}, {{(PE*DW-RW){1'b0}}, q[0].ro});
                if (out_ready) void'(q.pop_front());
                else chk("in_ready_stall", {127'b0, in_ready}, '0);
            end
        end
    end

    task automatic send(input logic [PE*DW-1:0] ta, input logic [PE*DW-1:0] tb_,
                        input logic [2:0] op, input logic [PE-1:0] en, input logic red,
                        input logic [PE*DW-1:0] e_pe, input logic e_rv, input logic [RW-1:0] e_ro,
                        input bit push);
        bit   acc = 1'b0;
        int   n = 0;
        exp_t e;
        in_valid = 1'b1;
        a = ta; b = tb_; pe_op = op; lane_en = en; red_en = red;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n = n + 1;
        end
        in_valid = 1'b0;
        if (!acc) begin
            checks = checks + 1;
            failures = failures + 1;
            $display("FAIL accept_timeout actual=no_accept required=accept");
        end else if (push) begin
            e.pe = e_pe; e.rv = e_rv; e.ro = e_ro;
            q.push_back(e);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n = n + 1;
        end
        chk("drain_empty", 128'(q.size()), '0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset with a live bundle on the inputs
        in_valid = 1'b1;
        a = pack(1, 2, 3, 4); b = pack(1, 1, 1, 1); lane_en = 4'hF; pe_op = OP_ADD;
        @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {127'b0, out_valid}, '0);
        chk("rst_pe_out", pe_out, '0);
        chk("rst_busy", {127'b0, busy}, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", {127'b0, in_ready}, 128'd1);
        chk("post_rst_out_valid", {127'b0, out_valid}, '0);
        @(posedge clk);
        #1;

        // latency: edges counted from the accept edge
        send(pack(4, 3, 2, 1), pack(10, 20, 30, 40), OP_ADD, 4'hF, 1'b0,
             pack(14, 23, 32, 41), 1'b0, '0, 1'b1);
        for (int k = 1; k < int'(PS); k++) begin
            @(negedge clk);
            chk("latency_early", {127'b0, out_valid}, '0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("latency_valid", {127'b0, out_valid}, 128'd1);
        @(posedge clk);
        #1;
        drain();

        // mask + reduction
        send(pack(5, -7, 100, 2), pack(1, 1, 1, 1), OP_ADD, 4'b1011, 1'b1,
             pack(6, -6, 100, 3), 1'b1, 35'd3, 1'b1);
        // subtract, all lanes
        send(pack(10, -5, 0, 7), pack(3, 5, 1, -7), OP_SUB, 4'hF, 1'b1,
             pack(7, -10, -1, 14), 1'b1, 35'd10, 1'b1);
        // no lanes enabled: pass-through, zero sum
        send(pack(1, 2, 3, 4), pack(15, 15, 15, 15), OP_AND, 4'h0, 1'b1,
             pack(1, 2, 3, 4), 1'b1, 35'd0, 1'b1);
        // reduction extremes
        send(pack(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF), '0, OP_ADD, 4'hF, 1'b1,
             pack(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF), 1'b1, 35'h1_FFFF_FFFC, 1'b1);
        send(pack(32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000), '0, OP_ADD, 4'hF, 1'b1,
             pack(32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000), 1'b1, 35'h6_0000_0000, 1'b1);
        drain();

        // backpressure: 3-cycle stall in the middle of a 5-bundle stream
        stall_from = cyc + 2;
        send(pack(1, 1, 1, 1), pack(10, 20, 30, 40), OP_ADD, 4'hF, 1'b1, pack(11, 21, 31, 41), 1'b1, 35'd104, 1'b1);
        send(pack(2, 2, 2, 2), pack(10, 20, 30, 40), OP_ADD, 4'hF, 1'b0, pack(12, 22, 32, 42), 1'b0, '0, 1'b1);
        send(pack(3, 3, 3, 3), pack(10, 20, 30, 40), OP_ADD, 4'hF, 1'b1, pack(13, 23, 33, 43), 1'b1, 35'd112, 1'b1);
        send(pack(4, 4, 4, 4), pack(10, 20, 30, 40), OP_ADD, 4'hF, 1'b0, pack(14, 24, 34, 44), 1'b0, '0, 1'b1);
        send(pack(5, 5, 5, 5), pack(10, 20, 30, 40), OP_ADD, 4'hF, 1'b1, pack(15, 25, 35, 45), 1'b1, 35'd120, 1'b1);
        drain();

        // mid-flight reset drops in-flight bundles
        for (int r = 0; r < 2; r++) begin
            send(pack(9, 9, 9, 9), pack(r, r, r, r), OP_ADD, 4'hF, 1'b1, '0, 1'b0, '0, 1'b0);
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                chk("flush_out_valid", {127'b0, out_valid}, '0);
                @(posedge clk);
                #1;
            end
        end
        @(negedge clk);
        chk("final_busy", {127'b0, busy}, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pe_array_pipe.md
Name: pe_array_pipe

Overview:
Parametrised successor to the single-register PE array. It contains PE_COUNT lanes, each built from the existing pe unit. The block adds a valid/ready streaming handshake, configurable pipeline depth, per-lane enable masking, and an optional horizontal sum-reduction output. It sits between the operand fetch/vector register read stage and writeback in the SIMD datapath.

Parameters:
PE_COUNT, 4, number of lanes (>=1)
DATA_WIDTH, 32, lane operand/result width (two's complement)
PIPE_STAGES, 2, register stages after the pe combinational logic (>=1); sets latency
RED_WIDTH, DATA_WIDTH+$clog2(PE_COUNT)+1, reduction result width (derived; do not override)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  operand bundle valid
in_ready  out  1  block can accept a bundle this cycle
a  in  PE_COUNT x DATA_WIDTH  lane operand A (packed, lane 0 = LSBs)
b  in  PE_COUNT x DATA_WIDTH  lane operand B
pe_op  in  OP_SEL_WIDTH  operation select, encoding per params.svh, shared by all lanes
lane_en  in  PE_COUNT  per-lane enable mask, captured with the bundle
red_en  in  1  request horizontal reduction for this bundle
out_valid  out  1  result bundle valid
out_ready  in  1  downstream accepts result
pe_out  out  PE_COUNT x DATA_WIDTH  per-lane results
red_out  out  RED_WIDTH  signed sum of enabled lane results (valid only when red_valid)
red_valid  out  1  red_out meaningful for current output bundle
busy  out  1  any stage holds a valid bundle

Behaviour:
- Reset, while rst=1 at a clock edge: all stage valid bits clear, and pe_out, red_out, red_valid, out_valid, busy go to 0. in_ready goes to 1 in the cycle after reset deasserts. A reset issued mid-operation drops all in-flight bundles and produces no output for them.
- Accept: a bundle is accepted when in_valid && in_ready. The block captures a, b, pe_op, lane_en, and red_en.
- Pipeline advance: global stall rule, advance = !out_valid || out_ready, and in_ready = advance. When advance=0, every stage holds its contents and valid bit.
- Bubbles: while advancing, empty stages propagate valid=0. Bubbles are not collapsed.
- Stage 1 computes lane i's pe result c[i] = pe(a[i], b[i], pe_op) combinationally from the accepted inputs and registers it, with lane_en and red_en travelling alongside.
- Stages 2..PIPE_STAGES are pure delay registers. Latency is exactly PIPE_STAGES cycles from the accept edge to out_valid=1 when there is no stall. Throughput is one bundle per cycle.
- Masking: if lane_en[i]=0, lane i result = a[i] unchanged (pass-through), and the lane is excluded from the reduction.
- Reduction:
  - Computed in the final stage from the lane results.
  - red_out = sum over enabled lanes of sign-extended results, at full RED_WIDTH, with no overflow or wrap.
  - red_valid = red_en of that bundle && out_valid.
  - If red_en=1 and lane_en=0, then red_out=0 and red_valid=1.
- Output hold: while out_valid && !out_ready, pe_out, red_out, and red_valid stay stable. out_valid never deasserts without a handshake or a reset.
- Simultaneous events: an output handshake and an input accept in the same cycle both occur, and the pipeline shifts by one.
- pe_op outside the defined encodings: lane result is whatever pe produces. The block itself adds no special handling.
- busy = OR of all stage valid bits.

Test Plan:
- Reset: drive rst=1 for 2 cycles with in_valid=1 -> out_valid=0, pe_out=0, busy=0. in_ready=1 the first cycle after rst=0.
- Latency/add (PIPE_STAGES=2): pe_op=OP_ADD, a={4,3,2,1}, b={10,20,30,40}, lane_en=4'hF, out_ready=1 -> exactly 2 cycles later out_valid=1, pe_out={14,23,32,41}.
- Backpressure: stream 5 add bundles back-to-back with out_ready low for 3 cycles mid-stream -> no bundle lost or duplicated, order preserved. in_ready=0 while out_valid && !out_ready. Outputs stay stable during the stall.
- Mask + reduction: a={5,-7,100,2}, b={1,1,1,1}, OP_ADD, lane_en=4'b1011, red_en=1 -> pe_out={6,-6,100,3} (lane 2 passes a=100), red_out=3, red_valid=1.
- Reduction width: PE_COUNT=4, all lanes = 0x7FFFFFFF + 0 -> red_out=0x1_FFFF_FFFC with no wrap. A negative case, all lanes -2^31, -> red_out=-2^33.
- Mid-flight reset: accept 2 bundles, assert rst for 1 cycle before they emerge -> out_valid stays 0 and neither result ever appears.
